// File: rtl/crc32_frame_seq.sv
// crc32_frame_seq: forwards byte frames and appends the IEEE CRC-32 produced by an external engine.
// Define CRC_CHECK_EN to add chk_mode, which verifies a trailing CRC instead of appending one.
module crc32_frame_seq #(
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             crc_reset,
    output logic             crc_we,
    output logic [7:0]       crc_byte,
    input  logic [31:0]      crc_value,
    output logic [LEN_W-1:0] frm_len,
`ifdef CRC_CHECK_EN
    input  logic             chk_mode,
    output logic             chk_done,
    output logic             chk_ok,
`endif
    output logic             frm_err
);

    typedef enum logic [1:0] {IDLE, DATA, WAIT, APPEND} state_t;

    localparam logic [LEN_W-1:0] CNT_MAX   = '1;
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    state_t           r_state;
    logic [LEN_W-1:0] r_count;
    logic [31:0]      r_crc_q;
    logic [1:0]       r_idx;
    logic [LEN_W-1:0] r_frm_len;
    logic             r_frm_err;
    logic             w_fire;
    logic [LEN_W-1:0] w_body;

`ifdef CRC_CHECK_EN
    logic             r_chk_mode;
    logic [3:0][7:0]  r_dly;        // [0] newest byte, [3] oldest
    logic             r_chk_done;
    logic             r_chk_ok;

    assign chk_done = r_chk_done;
    assign chk_ok   = r_chk_ok;
`endif

    assign frm_len = r_frm_len;
    assign frm_err = r_frm_err;
    assign w_fire  = (r_state == DATA) && s_valid && m_ready;

    // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_last    = 1'b0;
        crc_reset = 1'b1;
        crc_we    = 1'b0;
        crc_byte  = '0;
        case (r_state)
            DATA: begin
                crc_reset = 1'b0;
                s_ready   = m_ready;
                m_valid   = s_valid;
                m_data    = s_data;
                // Engine write is combinational so the final CRC is ready in the WAIT cycle.
                crc_we    = w_fire;
                crc_byte  = s_data;
`ifdef CRC_CHECK_EN
                if (r_chk_mode) begin
                    m_last   = s_last;
                    crc_we   = w_fire && (r_count >= LEN_W'(4));
                    crc_byte = r_dly[3];
                end
`endif
            end
            WAIT: crc_reset = 1'b0;
            APPEND: begin
                m_valid = 1'b1;
                m_data  = r_crc_q[{r_idx, 3'b000} +: 8];
                m_last  = (r_idx == 2'd3);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_body = r_count;
`ifdef CRC_CHECK_EN
        if (r_chk_mode)
            w_body = (r_count >= LEN_W'(4)) ? r_count - LEN_W'(4) : '0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_crc_q   <= '0;
            r_idx     <= '0;
            r_frm_len <= '0;
            r_frm_err <= 1'b0;
`ifdef CRC_CHECK_EN
            r_chk_mode <= 1'b0;
            r_dly      <= '0;
            r_chk_done <= 1'b0;
            r_chk_ok   <= 1'b0;
`endif
        end else begin
            r_frm_err <= 1'b0;
`ifdef CRC_CHECK_EN
            r_chk_done <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        r_state <= DATA;
                        r_count <= '0;
`ifdef CRC_CHECK_EN
                        r_chk_mode <= chk_mode;
`endif
                    end
                end
                DATA: begin
                    if (w_fire) begin
                        if (r_count != CNT_MAX)
                            r_count <= r_count + 1'b1;
`ifdef CRC_CHECK_EN
                        r_dly <= {r_dly[2:0], s_data};
`endif
                        if (s_last)
                            r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_crc_q   <= crc_value;
                    r_idx     <= '0;
                    r_frm_len <= w_body;
                    r_frm_err <= (w_body > MAX_LEN_C);
                    r_state   <= APPEND;
`ifdef CRC_CHECK_EN
                    if (r_chk_mode) begin
                        r_state    <= IDLE;
                        r_chk_done <= 1'b1;
                        r_chk_ok   <= (r_count >= LEN_W'(5)) &&
                                      ({r_dly[0], r_dly[1], r_dly[2], r_dly[3]} == crc_value);
                    end
`endif
                end
                APPEND: begin
                    if (m_ready) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3)
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_frame_seq.sv
// Testbench for crc32_frame_seq: models the CRC-32 engine and scoreboards every downstream byte.
// Define CRC_CHECK_EN to also exercise the check-mode sequences.
module tb_crc32_frame_seq;

    localparam int MAX_LEN = 1518;
    localparam int LEN_W   = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [7:0]       s_data = '0;
    logic             s_last = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [7:0]       m_data;
    logic             m_last;
    logic             crc_reset;
    logic             crc_we;
    logic [7:0]       crc_byte;
    logic [31:0]      crc_value;
    logic [LEN_W-1:0] frm_len;
    logic             frm_err;
`ifdef CRC_CHECK_EN
    logic             chk_mode = 1'b0;
    logic             chk_done;
    logic             chk_ok;
`endif

    always #5 clk = ~clk;

    crc32_frame_seq #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .crc_reset (crc_reset),
        .crc_we    (crc_we),
        .crc_byte  (crc_byte),
        .crc_value (crc_value),
        .frm_len   (frm_len),
`ifdef CRC_CHECK_EN
        .chk_mode  (chk_mode),
        .chk_done  (chk_done),
        .chk_ok    (chk_ok),
`endif
        .frm_err   (frm_err)
    );

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // External CRC-32 engine: synchronous active-high reset, result valid the cycle after rx_we.
    logic [31:0] eng_r;
    always @(posedge clk) begin
        if (crc_reset)   eng_r <= 32'hFFFFFFFF;
        else if (crc_we) eng_r <= crc_step(eng_r, crc_byte);
    end
    assign crc_value = ~eng_r;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    logic [7:0] fbuf [0:2047];
    logic [8:0] sb_q [$];
    int         frames_done = 0;
    int         err_pulses  = 0;
    int         chk_pulses  = 0;
    logic       last_chk_ok = 1'b0;
    bit         stall_mode  = 1'b0;
    logic       prev_stall  = 1'b0;
    logic [8:0] prev_out    = '0;

    function automatic logic [31:0] crc_ref(input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) c = crc_step(c, fbuf[i]);
        return ~c;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = stall_mode ? ~m_ready : 1'b1;
    end

    // Monitor: samples just after the falling edge, when all inputs and outputs are settled.
    initial forever begin
        logic [8:0] exp;
        @(negedge clk);
        #1;
        if (!reset_n) begin
            prev_stall = 1'b0;
            continue;
        end
        if (prev_stall) begin
            check("stall_hold_valid", m_valid, 1);
            check("stall_hold_data", {m_last, m_data}, prev_out);
        end
        prev_stall = m_valid && !m_ready;
        prev_out   = {m_last, m_data};
        if (!m_ready) check("s_ready_while_stalled", s_ready, 0);
        if (frm_err) err_pulses++;
`ifdef CRC_CHECK_EN
        if (chk_done) begin
            chk_pulses++;
            last_chk_ok = chk_ok;
        end
`endif
        if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got 0x%0h expected no byte", {m_last, m_data});
            end else begin
                exp = sb_q.pop_front();
                check("out_byte", {m_last, m_data}, exp);
                if (exp[8]) frames_done++;
            end
        end
    end

    // Drives fbuf[0..len-1]; expected output bytes enter the scoreboard as each byte is accepted.
    task automatic send_frame(input int len, input bit chk, input logic [31:0] crc, input bit abort);
        for (int i = 0; i < len; i++) begin
            bit last;
            bit accepted;
            int n;
            last     = (i == len - 1) && !abort;
            accepted = 1'b0;
            n        = 0;
            s_valid  = 1'b1;
            s_data   = fbuf[i];
            s_last   = last;
            while (!accepted) begin
                @(negedge clk);
                if (s_ready) begin
                    sb_q.push_back({chk ? last : 1'b0, fbuf[i]});
                    if (last && !chk)
                        for (int k = 0; k < 4; k++) sb_q.push_back({k == 3, crc[8*k +: 8]});
                    accepted = 1'b1;
                end else if (++n > 200) begin
                    n_total++;
                    $display("FAIL accept_timeout: byte %0d never accepted", i);
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (frames_done < target) begin
            n_total++;
            $display("FAIL %s_timeout: frames done %0d expected %0d", name, frames_done, target);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          len;
        logic [7:0]  first;
        bit          stall;
        logic [31:0] exp_crc;
        logic        exp_err;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int base;
        vecs[0] = '{9, 8'h31, 1'b0, 32'hCBF43926, 1'b0};
        vecs[1] = '{1, 8'h00, 1'b0, 32'hD202EF8D, 1'b0};
        vecs[2] = '{9, 8'h31, 1'b1, 32'hCBF43926, 1'b0};
        vecs[3] = '{3, 8'h61, 1'b0, 32'h352441C2, 1'b0};
        vecs[4] = '{1, 8'h61, 1'b1, 32'hE8B7BE43, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_crc_we", crc_we, 0);
        check("rst_frm_err", frm_err, 0);
        check("rst_crc_reset", crc_reset, 1);
        check("rst_m_data", m_data, 0);
        check("rst_crc_byte", crc_byte, 0);
        check("rst_frm_len", frm_len, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            stall_mode = vecs[v].stall;
            for (int i = 0; i < vecs[v].len; i++) fbuf[i] = vecs[v].first + 8'(i);
            err_pulses = 0;
            base = frames_done;
            send_frame(vecs[v].len, 1'b0, vecs[v].exp_crc, 1'b0);
            wait_done(base + 1, "vec");
            stall_mode = 1'b0;
            check("vec_frm_len", frm_len, vecs[v].len);
            check("vec_frm_err_pulses", err_pulses, vecs[v].exp_err);
            check("vec_sb_drained", sb_q.size(), 0);
        end

        // Length boundary: MAX_LEN is clean, MAX_LEN+1 flags frm_err once.
        for (int len = MAX_LEN; len <= MAX_LEN + 1; len++) begin
            for (int i = 0; i < len; i++) fbuf[i] = 8'(i * 7 + 3);
            err_pulses = 0;
            base = frames_done;
            send_frame(len, 1'b0, crc_ref(len), 1'b0);
            wait_done(base + 1, "long");
            check("long_frm_len", frm_len, len);
            check("long_frm_err_pulses", err_pulses, (len > MAX_LEN) ? 1 : 0);
        end

        // Reset asserted mid-frame after 4 bytes, with a fifth byte on offer.
        for (int i = 0; i < 9; i++) fbuf[i] = 8'h31 + 8'(i);
        send_frame(4, 1'b0, 32'h0, 1'b1);
        s_valid = 1'b1;
        s_data  = fbuf[4];
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_crc_reset", crc_reset, 1);
        check("midrst_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        reset_n = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        base = frames_done;
        send_frame(9, 1'b0, 32'hCBF43926, 1'b0);
        wait_done(base + 1, "post_rst");
        check("post_rst_frm_len", frm_len, 9);

`ifdef CRC_CHECK_EN
        chk_mode = 1'b1;
        fbuf[9]  = 8'h26;
        fbuf[10] = 8'h39;
        fbuf[11] = 8'hF4;
        fbuf[12] = 8'hCB;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) fbuf[12] = 8'hCA;
            chk_pulses = 0;
            base = frames_done;
            send_frame(13, 1'b1, 32'h0, 1'b0);
            wait_done(base + 1, "chk");
            check("chk_done_pulses", chk_pulses, 1);
            check("chk_ok", last_chk_ok, (pass == 0) ? 1 : 0);
            check("chk_frm_len", frm_len, 9);
        end
        for (int i = 0; i < 4; i++) fbuf[i] = 8'h00;
        chk_pulses = 0;
        base = frames_done;
        send_frame(4, 1'b1, 32'h0, 1'b0);
        wait_done(base + 1, "chk_short");
        check("chk_short_done", chk_pulses, 1);
        check("chk_short_ok", last_chk_ok, 0);
        check("chk_short_frm_len", frm_len, 0);
        chk_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
